// File: rtl/leaf_pkg.sv
// Shared widths, packet field positions and per-port scheduler state for the leaf output path.
package leaf_pkg;
   localparam int PACKET_BITS   = 49;
   localparam int PAYLOAD_BITS  = 32;
   localparam int NUM_LEAF_BITS = 5;
   localparam int NUM_PORT_BITS = 4;
   localparam int NUM_ADDR_BITS = 7;
   localparam int CREDIT_BITS   = NUM_ADDR_BITS + 1;

   localparam int LEAF_LSB = 44;
   localparam int PORT_LSB = 40;
   localparam int ADDR_LSB = 33;
   localparam int FLAG_BIT = 32;

   typedef struct packed {
      logic                     en;
      logic [NUM_LEAF_BITS-1:0] dest_leaf;
      logic [NUM_PORT_BITS-1:0] dest_port;
      logic [NUM_ADDR_BITS-1:0] addr;
      logic [CREDIT_BITS-1:0]   credit;
   } port_state_t;

   function automatic logic [PACKET_BITS-1:0] make_pkt(input port_state_t s,
                                                        input logic [PAYLOAD_BITS-1:0] payload);
      make_pkt = {s.dest_leaf, s.dest_port, s.addr, 1'b1, payload};
   endfunction
endpackage

// File: rtl/leaf_out_sched_if.sv
// Packet bus from the leaf output scheduler to the BFT.
interface leaf_out_sched_if;
   import leaf_pkg::*;

   logic [PACKET_BITS-1:0] dout_pkt;
   logic                   dout_vld;
   logic                   dout_ack;

   modport master (output dout_pkt, output dout_vld, input dout_ack);
   modport slave  (input dout_pkt, input dout_vld, output dout_ack);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr.
module rr_arbiter #(
   parameter int N = 4,
   localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt
);
   always_comb begin
      logic             found;
      logic [PTR_W-1:0] idx;
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = PTR_W'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/leaf_out_sched.sv
// Credit-gated round-robin scheduler of user output streams onto the leaf's single BFT packet register.
module leaf_out_sched
   import leaf_pkg::*;
#(
   parameter int NUM_OUT_PORTS         = 4,
   parameter int FREESPACE_UPDATE_SIZE = 64
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
   input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
   output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
   input  logic                                  cfg_wr_en,
   input  logic [NUM_PORT_BITS-1:0]              cfg_port,
   input  logic [NUM_LEAF_BITS-1:0]              cfg_dest_leaf,
   input  logic [NUM_PORT_BITS-1:0]              cfg_dest_port,
   input  logic                                  credit_vld,
   input  logic [NUM_PORT_BITS-1:0]              credit_port,
   input  logic [CREDIT_BITS-1:0]                credit_amt,
   leaf_out_sched_if.master                      bft
);
   localparam int PTR_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
   localparam int SUM_W = CREDIT_BITS + 2;
   localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = CREDIT_BITS'(FREESPACE_UPDATE_SIZE);
   localparam logic [SUM_W-1:0]       SUM_MAX    = SUM_W'(FREESPACE_UPDATE_SIZE);

   port_state_t st     [NUM_OUT_PORTS];
   port_state_t st_nxt [NUM_OUT_PORTS];

   logic [PTR_W-1:0]         rr_ptr;
   logic [PTR_W-1:0]         rr_ptr_nxt;
   logic [NUM_OUT_PORTS-1:0] req;
   logic [NUM_OUT_PORTS-1:0] gnt;
   logic                     out_free;
   logic                     gnt_any;
   logic [PACKET_BITS-1:0]   pkt_nxt;
   logic [SUM_W-1:0]         credit_sum;

   // The register can take a new beat in the same cycle the held one is accepted.
   assign out_free = !bft.dout_vld || bft.dout_ack;

   always_comb begin
      req = '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++)
         req[i] = out_free && vld_user2interface[i] && st[i].en && (st[i].credit != '0);
   end

   rr_arbiter #(.N(NUM_OUT_PORTS)) u_arb (
      .req (req),
      .ptr (rr_ptr),
      .gnt (gnt)
   );

   assign ack_interface2user = gnt;
   assign gnt_any            = |gnt;

   always_comb begin
      pkt_nxt    = '0;
      rr_ptr_nxt = rr_ptr;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         if (gnt[i]) begin
            pkt_nxt    = make_pkt(st[i], din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]);
            rr_ptr_nxt = PTR_W'((i + 1) % NUM_OUT_PORTS);
         end
      end
   end

   // Configuration overrides any same-cycle grant or credit update on that port.
   always_comb begin
      credit_sum = '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         st_nxt[i]  = st[i];
         credit_sum = SUM_W'(st[i].credit);
         if (credit_vld && (credit_port == NUM_PORT_BITS'(i + 1)) && st[i].en)
            credit_sum = credit_sum + SUM_W'(credit_amt);
         if (gnt[i]) begin
            credit_sum     = credit_sum - SUM_W'(1);
            st_nxt[i].addr = st[i].addr + 1'b1;
         end
         st_nxt[i].credit = (credit_sum > SUM_MAX) ? CREDIT_MAX : credit_sum[CREDIT_BITS-1:0];
         if (cfg_wr_en && (cfg_port == NUM_PORT_BITS'(i + 1))) begin
            st_nxt[i].en        = 1'b1;
            st_nxt[i].dest_leaf = cfg_dest_leaf;
            st_nxt[i].dest_port = cfg_dest_port;
            st_nxt[i].addr      = '0;
            st_nxt[i].credit    = CREDIT_MAX;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_OUT_PORTS; i++)
            st[i] <= '0;
         rr_ptr       <= '0;
         bft.dout_pkt <= '0;
         bft.dout_vld <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_OUT_PORTS; i++)
            st[i] <= st_nxt[i];
         rr_ptr <= rr_ptr_nxt;
         if (gnt_any) begin
            bft.dout_pkt <= pkt_nxt;
            bft.dout_vld <= 1'b1;
         end else if (bft.dout_ack) begin
            bft.dout_vld <= 1'b0;
         end
      end
   end
endmodule
